// File: rtl/range_updown_counter.sv
// Up/down counter over a programmable closed range [LOW, HIGH] with load, enable,
// wrap/saturate mode, ripple terminal count and a registered wrap pulse.
// Optional: define RANGE_COUNTER_LOAD_CLAMP_EN to clamp parallel-load data into range.
module range_updown_counter #(
    parameter int WIDTH    = 4,
    parameter int LOW      = 2,
    parameter int HIGH     = 9,
    parameter int SATURATE = 0
) (
    input  logic             CP,
    input  logic             _CLR,
    input  logic             EN,
    input  logic             M,
    input  logic             _LD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             _TC,
    output logic             _Qcc
);

    localparam logic [WIDTH-1:0] LowVal  = LOW[WIDTH-1:0];
    localparam logic [WIDTH-1:0] HighVal = HIGH[WIDTH-1:0];
    localparam logic             SatMode = (SATURATE != 0);

    logic [WIDTH-1:0] count_q, count_d;
    logic             qcc_q, qcc_d;
    logic [WIDTH-1:0] loadValue;
    logic [WIDTH-1:0] terminalValue;
    logic [WIDTH-1:0] wrapValue;
    logic             atTerminal;
    logic             outOfRange;

`ifdef RANGE_COUNTER_LOAD_CLAMP_EN
    always_comb begin
        loadValue = D;
        if (D < LowVal) begin
            loadValue = LowVal;
        end else if (D > HighVal) begin
            loadValue = HighVal;
        end
    end
`else
    assign loadValue = D;
`endif

    // The terminal is the bound being approached; the wrap target is the opposite bound.
    assign terminalValue = M ? HighVal : LowVal;
    assign wrapValue     = M ? LowVal : HighVal;
    assign atTerminal    = (count_q == terminalValue);
    assign outOfRange    = (count_q < LowVal) || (count_q > HighVal);

    always_comb begin
        count_d = count_q;
        qcc_d   = 1'b1;
        if (!_LD) begin
            count_d = loadValue;
        end else if (EN) begin
            qcc_d = ~atTerminal;
            if (outOfRange) begin
                count_d = wrapValue;
            end else if (atTerminal) begin
                count_d = SatMode ? count_q : wrapValue;
            end else if (M) begin
                count_d = count_q + WIDTH'(1);
            end else begin
                count_d = count_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge CP or negedge _CLR) begin
        if (!_CLR) begin
            count_q <= LowVal;
            qcc_q   <= 1'b1;
        end else begin
            count_q <= count_d;
            qcc_q   <= qcc_d;
        end
    end

    // Terminal count stays combinational so cascaded stages see it within the same cycle.
    assign _TC  = ~(EN & atTerminal);
    assign Q    = count_q;
    assign _Qcc = qcc_q;

endmodule

// File: tb/tb_range_updown_counter.sv
// Randomised and directed bench for range_updown_counter against an arithmetic range model.
// Covers wrap and saturate instances plus a two-digit decimal cascade.
module tb_range_updown_counter;

    logic       cp;
    logic       clrN;
    logic       enA, mA, ldA;
    logic [3:0] dA;
    logic [3:0] qA;
    logic       tcA, qccA;
    logic       enB, mB, ldB;
    logic [3:0] dB;
    logic [3:0] qB;
    logic       tcB, qccB;
    logic       en1;
    logic       en2;
    logic [3:0] q1, q2;
    logic       tc1, tc2, qcc1, qcc2;

    int checks;
    int failures;
    int qa, qb;
    logic qcca, qccb;

    range_updown_counter #(.WIDTH(4), .LOW(2), .HIGH(9), .SATURATE(0)) dutA (
        .CP(cp), ._CLR(clrN), .EN(enA), .M(mA), ._LD(ldA), .D(dA),
        .Q(qA), ._TC(tcA), ._Qcc(qccA)
    );

    range_updown_counter #(.WIDTH(4), .LOW(2), .HIGH(9), .SATURATE(1)) dutB (
        .CP(cp), ._CLR(clrN), .EN(enB), .M(mB), ._LD(ldB), .D(dB),
        .Q(qB), ._TC(tcB), ._Qcc(qccB)
    );

    range_updown_counter #(.WIDTH(4), .LOW(0), .HIGH(9), .SATURATE(0)) stage1 (
        .CP(cp), ._CLR(clrN), .EN(en1), .M(1'b1), ._LD(1'b1), .D(4'd0),
        .Q(q1), ._TC(tc1), ._Qcc(qcc1)
    );

    assign en2 = ~tc1;

    range_updown_counter #(.WIDTH(4), .LOW(0), .HIGH(9), .SATURATE(0)) stage2 (
        .CP(cp), ._CLR(clrN), .EN(en2), .M(1'b1), ._LD(1'b1), .D(4'd0),
        .Q(q2), ._TC(tc2), ._Qcc(qcc2)
    );

    initial cp = 1'b0;
    always #5 cp = ~cp;

    function automatic int clampLoad(int d, int low, int high);
`ifdef RANGE_COUNTER_LOAD_CLAMP_EN
        if (d < low) return low;
        if (d > high) return high;
`endif
        return d;
    endfunction

    // Counting is modelled as a position modulo the span of the range.
    function automatic int modelNext(int q, int low, int high, bit sat,
                                     bit ld, bit en, bit m, int d);
        int span;
        span = high - low + 1;
        if (!ld) return clampLoad(d, low, high);
        if (!en) return q;
        if (q < low || q > high) return m ? low : high;
        if (sat) begin
            if (m) return (q + 1 > high) ? high : q + 1;
            return (q - 1 < low) ? low : q - 1;
        end
        if (m) return low + (q - low + 1) % span;
        return low + (q - low - 1 + span) % span;
    endfunction

    function automatic logic modelQccN(int q, int low, int high, bit ld, bit en, bit m);
        return !(ld && en && q == (m ? high : low));
    endfunction

    function automatic logic modelTcN(int q, int low, int high, bit en, bit m);
        return !(en && q == (m ? high : low));
    endfunction

    task automatic resetModels();
        qa = 2; qcca = 1'b1;
        qb = 2; qccb = 1'b1;
    endtask

    task automatic step();
        int nqa, nqb;
        logic nca, ncb;
        nqa = modelNext(qa, 2, 9, 1'b0, ldA, enA, mA, int'(dA));
        nca = modelQccN(qa, 2, 9, ldA, enA, mA);
        nqb = modelNext(qb, 2, 9, 1'b1, ldB, enB, mB, int'(dB));
        ncb = modelQccN(qb, 2, 9, ldB, enB, mB);
        @(posedge cp);
        #1;
        qa = nqa; qcca = nca;
        qb = nqb; qccb = ncb;
    endtask

    task automatic test_reset();
        enA = 1'b1; mA = 1'b1; ldA = 1'b1; dA = 4'd0;
        enB = 1'b0; mB = 1'b1; ldB = 1'b1; dB = 4'd0;
        en1 = 1'b0;
        clrN = 1'b0;
        #3;
        resetModels();
        repeat (2) @(posedge cp);
        #1;
        checks++;
        if (qA !== 4'd2) begin
            failures++;
            $display("[TB] FAIL reset_q: got %0d expected 2", qA);
        end
        checks++;
        if (qccA !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_qcc: got %b expected 1", qccA);
        end
        checks++;
        if (tcA !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_tc_up: got %b expected 1", tcA);
        end
        mA = 1'b0;
        #1;
        checks++;
        if (tcA !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_tc_down: got %b expected 0", tcA);
        end
        mA = 1'b1;
        #1;
        clrN = 1'b1;
    endtask

    task automatic test_up_wrap();
        enA = 1'b1; mA = 1'b1; ldA = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            checks++;
            if (qA !== 4'(qa) || qccA !== qcca) begin
                failures++;
                $display("[TB] FAIL up_wrap[%0d]: got q=%0d qcc=%b expected q=%0d qcc=%b",
                         i, qA, qccA, qa, qcca);
            end
            checks++;
            if (tcA !== modelTcN(qa, 2, 9, enA, mA)) begin
                failures++;
                $display("[TB] FAIL up_wrap_tc[%0d]: got %b expected %b",
                         i, tcA, modelTcN(qa, 2, 9, enA, mA));
            end
        end
    endtask

    task automatic test_down_wrap();
        enA = 1'b1; mA = 1'b0; ldA = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (qA !== 4'(qa) || qccA !== qcca || tcA !== modelTcN(qa, 2, 9, enA, mA)) begin
                failures++;
                $display("[TB] FAIL down_wrap[%0d]: got q=%0d qcc=%b tc=%b expected q=%0d qcc=%b",
                         i, qA, qccA, tcA, qa, qcca);
            end
        end
    endtask

    task automatic test_load_priority();
        enA = 1'b1; mA = 1'b1;
        ldA = 1'b0; dA = 4'd5;
        step();
        dA = 4'd7;
        step();
        checks++;
        if (qA !== 4'd7 || qccA !== 1'b1) begin
            failures++;
            $display("[TB] FAIL load_priority: got q=%0d qcc=%b expected q=7 qcc=1", qA, qccA);
        end
        dA = 4'd14;
        step();
        checks++;
        if (qA !== 4'(qa)) begin
            failures++;
            $display("[TB] FAIL load_out_of_range: got %0d expected %0d", qA, qa);
        end
        ldA = 1'b1;
        step();
        checks++;
        if (qA !== 4'd2 || qccA !== qcca) begin
            failures++;
            $display("[TB] FAIL load_recovery: got q=%0d qcc=%b expected q=2 qcc=%b",
                     qA, qccA, qcca);
        end
    endtask

    task automatic test_saturate();
        enA = 1'b0;
        ldB = 1'b0; dB = 4'd8; enB = 1'b1; mB = 1'b1;
        step();
        ldB = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (qB !== 4'(qb) || qccB !== qccb) begin
                failures++;
                $display("[TB] FAIL saturate_up[%0d]: got q=%0d qcc=%b expected q=%0d qcc=%b",
                         i, qB, qccB, qb, qccb);
            end
        end
        mB = 1'b0;
        step();
        checks++;
        if (qB !== 4'd8 || qccB !== 1'b1) begin
            failures++;
            $display("[TB] FAIL saturate_leave: got q=%0d qcc=%b expected q=8 qcc=1", qB, qccB);
        end
        enB = 1'b0;
    endtask

    task automatic test_async_reset();
        ldA = 1'b0; dA = 4'd5; enA = 1'b1; mA = 1'b1;
        step();
        ldA = 1'b1;
        step();
        #2;
        clrN = 1'b0;
        #1;
        checks++;
        if (qA !== 4'd2 || qccA !== 1'b1) begin
            failures++;
            $display("[TB] FAIL async_reset: got q=%0d qcc=%b expected q=2 qcc=1", qA, qccA);
        end
        @(posedge cp);
        #1;
        checks++;
        if (qA !== 4'd2) begin
            failures++;
            $display("[TB] FAIL async_reset_hold: got %0d expected 2", qA);
        end
        #2;
        clrN = 1'b1;
        resetModels();
        step();
        checks++;
        if (qA !== 4'(qa)) begin
            failures++;
            $display("[TB] FAIL async_reset_first_count: got %0d expected %0d", qA, qa);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            ldA = ($urandom_range(0, 5) != 0);
            enA = ($urandom_range(0, 3) != 0);
            mA  = 1'($urandom_range(0, 1));
            dA  = 4'($urandom_range(0, 15));
            ldB = ($urandom_range(0, 5) != 0);
            enB = ($urandom_range(0, 3) != 0);
            mB  = 1'($urandom_range(0, 1));
            dB  = 4'($urandom_range(0, 15));
            step();
            checks++;
            if (qA !== 4'(qa) || qccA !== qcca || tcA !== modelTcN(qa, 2, 9, enA, mA)) begin
                failures++;
                $display("[TB] FAIL random_wrap[%0d]: got q=%0d qcc=%b tc=%b expected q=%0d qcc=%b tc=%b",
                         i, qA, qccA, tcA, qa, qcca, modelTcN(qa, 2, 9, enA, mA));
            end
            checks++;
            if (qB !== 4'(qb) || qccB !== qccb || tcB !== modelTcN(qb, 2, 9, enB, mB)) begin
                failures++;
                $display("[TB] FAIL random_sat[%0d]: got q=%0d qcc=%b tc=%b expected q=%0d qcc=%b tc=%b",
                         i, qB, qccB, tcB, qb, qccb, modelTcN(qb, 2, 9, enB, mB));
            end
        end
        enA = 1'b0; enB = 1'b0; ldA = 1'b1; ldB = 1'b1;
    endtask

    task automatic test_cascade();
        int count;
        int tensIncrements;
        int prevTens;
        clrN = 1'b0;
        #2;
        clrN = 1'b1;
        resetModels();
        en1 = 1'b1;
        tensIncrements = 0;
        prevTens = 0;
        for (int i = 1; i <= 100; i++) begin
            step();
            count = i % 100;
            if (int'(q2) != prevTens) tensIncrements++;
            prevTens = int'(q2);
            checks++;
            if (q1 !== 4'(count % 10) || q2 !== 4'(count / 10)) begin
                failures++;
                $display("[TB] FAIL cascade[%0d]: got %0d%0d expected %0d", i, q2, q1, count);
            end
            checks++;
            if (tc1 !== modelTcN(count % 10, 0, 9, 1'b1, 1'b1)) begin
                failures++;
                $display("[TB] FAIL cascade_tc[%0d]: got %b expected %b",
                         i, tc1, modelTcN(count % 10, 0, 9, 1'b1, 1'b1));
            end
        end
        checks++;
        if (tensIncrements != 10) begin
            failures++;
            $display("[TB] FAIL cascade_tens_steps: got %0d expected 10", tensIncrements);
        end
        en1 = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        clrN = 1'b1;
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load_priority();
        test_saturate();
        test_async_reset();
        test_random();
        test_cascade();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
